// File: rtl/bp_fe_pkg.sv
// Shared types and constants for the front-end branch history table controller.
package bp_fe_pkg;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StUpdRd,
    StUpdWr
  } bht_state_e;

  // 2-bit counter encodings: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] bht_ctr_init_c = 2'b01;
  localparam logic [1:0] bht_ctr_max_c  = 2'b11;
  localparam logic [1:0] bht_ctr_min_c  = 2'b00;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO with valid/ready enqueue and valid/yumi dequeue.
// A full FIFO still accepts an enqueue in a cycle where the head is consumed.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 4,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0] mem_q [els_p];
  logic [ptr_w_lp:0]  rd_ptr_q, wr_ptr_q;
  logic [ptr_w_lp:0]  rd_ptr_d, wr_ptr_d;
  logic               empty, full, enq, deq;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[ptr_w_lp-1:0] == wr_ptr_q[ptr_w_lp-1:0]) &&
                 (rd_ptr_q[ptr_w_lp] != wr_ptr_q[ptr_w_lp]);

  assign v_o     = ~empty;
  assign ready_o = ~full | yumi_i;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & ~empty;
  assign data_o  = mem_q[rd_ptr_q[ptr_w_lp-1:0]];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (deq) rd_ptr_d = rd_ptr_q + (ptr_w_lp + 1)'(1);
      if (enq) wr_ptr_d = wr_ptr_q + (ptr_w_lp + 1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq && !clear_i) mem_q[wr_ptr_q[ptr_w_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_fe_bht_ctrl.sv
// Branch history table controller: initializes a single-port 2-bit counter array,
// serves fetch lookups, and applies queued branch-resolution updates read-modify-write.
module bp_fe_bht_ctrl
  import bp_fe_pkg::*;
#(
  parameter int unsigned bht_idx_width_p = 3,
  parameter int unsigned upd_els_p       = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       clear_i,
  output logic                       init_done_o,

  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] r_idx_i,
  output logic                       r_ready_o,
  output logic                       predict_v_o,
  output logic                       predict_o,

  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] w_idx_i,
  input  logic                       w_taken_i,
  output logic                       w_ready_o,

  output logic                       mem_v_o,
  output logic                       mem_w_o,
  output logic [bht_idx_width_p-1:0] mem_addr_o,
  output logic [1:0]                 mem_data_o,
  input  logic [1:0]                 mem_data_i
);

  bht_state_e                 state_q;
  logic [bht_idx_width_p-1:0] init_cnt_q;
  logic                       init_run_q;
  logic                       init_done_q;
  logic                       predict_v_q;

  logic                       fifo_ready, fifo_v, fifo_yumi;
  logic [bht_idx_width_p:0]   fifo_data;
  logic [bht_idx_width_p-1:0] head_idx;
  logic                       head_taken;
  logic                       lookup_acc;
  logic [1:0]                 ctr_next;

  assign head_idx   = fifo_data[bht_idx_width_p:1];
  assign head_taken = fifo_data[0];

  assign r_ready_o  = (state_q == StIdle) || (state_q == StUpdRd);
  assign lookup_acc = r_v_i & r_ready_o;
  assign w_ready_o  = init_done_q & fifo_ready;
  assign fifo_yumi  = (state_q == StUpdWr) & ~clear_i;

  assign init_done_o = init_done_q;
  assign predict_v_o = predict_v_q;
  assign predict_o   = predict_v_q & mem_data_i[1];

  bsg_fifo_1r1w_small #(
    .width_p(bht_idx_width_p + 1),
    .els_p  (upd_els_p)
  ) u_upd_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (clear_i),
    .v_i      (w_v_i & init_done_q),
    .ready_o  (fifo_ready),
    .data_i   ({w_idx_i, w_taken_i}),
    .v_o      (fifo_v),
    .yumi_i   (fifo_yumi),
    .data_o   (fifo_data)
  );

  // Saturating update of the counter read back in UPD_RD.
  always_comb begin
    ctr_next = mem_data_i;
    if (head_taken) begin
      if (mem_data_i != bht_ctr_max_c) ctr_next = mem_data_i + 2'd1;
    end else begin
      if (mem_data_i != bht_ctr_min_c) ctr_next = mem_data_i - 2'd1;
    end
  end

  // Single array port: a lookup wins whenever it is accepted; r_ready_o is
  // already low in UPD_WR so the write-back cannot collide with it.
  always_comb begin
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (lookup_acc) begin
      mem_v_o    = 1'b1;
      mem_addr_o = r_idx_i;
    end else if (!clear_i) begin
      unique case (state_q)
        StInit: begin
          if (init_run_q) begin
            mem_v_o    = 1'b1;
            mem_w_o    = 1'b1;
            mem_addr_o = init_cnt_q;
            mem_data_o = bht_ctr_init_c;
          end
        end
        StUpdRd: begin
          mem_v_o    = 1'b1;
          mem_addr_o = head_idx;
        end
        StUpdWr: begin
          mem_v_o    = 1'b1;
          mem_w_o    = 1'b1;
          mem_addr_o = head_idx;
          mem_data_o = ctr_next;
        end
        StIdle: ;
      endcase
    end
  end

  // init_run_q holds off the first init write until the first edge after reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_run_q  <= 1'b0;
      init_done_q <= 1'b0;
      predict_v_q <= 1'b0;
    end else begin
      predict_v_q <= lookup_acc;
      init_run_q  <= 1'b1;
      if (clear_i) begin
        state_q     <= StInit;
        init_cnt_q  <= '0;
        init_done_q <= 1'b0;
      end else begin
        unique case (state_q)
          StInit: begin
            if (init_run_q) begin
              if (&init_cnt_q) begin
                state_q     <= StIdle;
                init_done_q <= 1'b1;
              end else begin
                init_cnt_q <= init_cnt_q + bht_idx_width_p'(1);
              end
            end
          end
          StIdle: begin
            if (fifo_v && !lookup_acc) state_q <= StUpdRd;
          end
          StUpdRd: begin
            if (!lookup_acc) state_q <= StUpdWr;
          end
          StUpdWr: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_bht_ctrl.sv
// Scoreboard bench for bp_fe_bht_ctrl with an 8-entry behavioural counter array.
module tb_bp_fe_bht_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       init_done_o;
  logic       r_v_i = 1'b0;
  logic [2:0] r_idx_i = '0;
  logic       r_ready_o;
  logic       predict_v_o, predict_o;
  logic       w_v_i = 1'b0;
  logic [2:0] w_idx_i = '0;
  logic       w_taken_i = 1'b0;
  logic       w_ready_o;
  logic       mem_v_o, mem_w_o;
  logic [2:0] mem_addr_o;
  logic [1:0] mem_data_o;
  logic [1:0] mem_data_i;

  logic [1:0]  arr [8];
  logic [31:0] exp_wr[$];
  logic [31:0] exp_pred[$];
  int          n_total = 0;
  int          n_pass  = 0;

  bp_fe_bht_ctrl #(
    .bht_idx_width_p(3),
    .upd_els_p      (4)
  ) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clear_i    (clear_i),
    .init_done_o(init_done_o),
    .r_v_i      (r_v_i),
    .r_idx_i    (r_idx_i),
    .r_ready_o  (r_ready_o),
    .predict_v_o(predict_v_o),
    .predict_o  (predict_o),
    .w_v_i      (w_v_i),
    .w_idx_i    (w_idx_i),
    .w_taken_i  (w_taken_i),
    .w_ready_o  (w_ready_o),
    .mem_v_o    (mem_v_o),
    .mem_w_o    (mem_w_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_v_o) begin
      if (mem_w_o) arr[mem_addr_o] <= mem_data_o;
      else         mem_data_i <= arr[mem_addr_o];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_lookup(input logic [2:0] idx, input logic exp_taken);
    bit done = 1'b0;
    r_v_i = 1'b1;
    r_idx_i = idx;
    exp_pred.push_back({31'b0, exp_taken});
    for (int i = 0; i < 10 && !done; i++) begin
      done = r_ready_o;
      cycle();
    end
    r_v_i = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL lookup_accept: r_ready_o stayed 0 for idx %0d, required 1 within 10 cycles", idx);
    end
  endtask

  task automatic do_update(input logic [2:0] idx, input logic taken, input logic [1:0] exp_val);
    bit done = 1'b0;
    w_v_i = 1'b1;
    w_idx_i = idx;
    w_taken_i = taken;
    exp_wr.push_back({27'b0, idx, exp_val});
    for (int i = 0; i < 10 && !done; i++) begin
      done = w_ready_o;
      cycle();
    end
    w_v_i = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL upd_accept: w_ready_o stayed 0 for idx %0d, required 1 within 10 cycles", idx);
    end
  endtask

  // Monitor: every array write and every prediction is matched against the queues.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk_i);
      if (reset_n_i) begin
        if (mem_v_o && mem_w_o) begin
          if (exp_wr.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_wr: got write addr %0d data %b, required no write",
                     mem_addr_o, mem_data_o);
          end else begin
            e = exp_wr.pop_front();
            chk("mem_wr", {27'b0, mem_addr_o, mem_data_o}, e);
          end
        end
        if (predict_v_o) begin
          if (exp_pred.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_pred: got predict_v_o=1 predict_o=%b, required none",
                     predict_o);
          end else begin
            e = exp_pred.pop_front();
            chk("predict", {31'b0, predict_o}, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic [1:0] g_vals [4];
    g_vals[0] = 2'b10;
    g_vals[1] = 2'b11;
    g_vals[2] = 2'b11;
    g_vals[3] = 2'b11;

    // Reset state
    #12;
    chk("rst_init_done", {31'b0, init_done_o}, 0);
    chk("rst_predict_v", {31'b0, predict_v_o}, 0);
    chk("rst_predict",   {31'b0, predict_o}, 0);
    chk("rst_mem_v",     {31'b0, mem_v_o}, 0);
    chk("rst_r_ready",   {31'b0, r_ready_o}, 0);
    chk("rst_w_ready",   {31'b0, w_ready_o}, 0);

    // Initialization: 01 written to 0..7, done in cycle 9
    for (int a = 0; a < 8; a++) exp_wr.push_back({27'b0, 3'(a), 2'b01});
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    n = 0;
    while (!init_done_o && n < 20) begin
      cycle();
      n++;
      if (n == 1) begin
        chk("init_r_ready", {31'b0, r_ready_o}, 0);
        chk("init_w_ready", {31'b0, w_ready_o}, 0);
      end
    end
    chk("init_done_cycle", n, 9);
    chk("init_writes_seen", exp_wr.size(), 0);

    // Lookups of freshly initialized entries
    do_lookup(3'd5, 1'b0);
    do_lookup(3'd0, 1'b0);

    // Taken updates saturate at 11
    do_update(3'd5, 1'b1, 2'b10);
    do_update(3'd5, 1'b1, 2'b11);
    repeat (8) cycle();
    do_lookup(3'd5, 1'b1);
    do_update(3'd5, 1'b1, 2'b11);
    repeat (6) cycle();
    do_lookup(3'd5, 1'b1);

    // Not-taken floors at 00, then climbs back
    do_update(3'd2, 1'b0, 2'b00);
    do_update(3'd2, 1'b0, 2'b00);
    repeat (8) cycle();
    do_lookup(3'd2, 1'b0);
    do_update(3'd2, 1'b1, 2'b01);
    do_update(3'd2, 1'b1, 2'b10);
    repeat (8) cycle();
    do_lookup(3'd2, 1'b1);

    // Update stalls in UPD_RD behind back-to-back lookups
    do_update(3'd3, 1'b1, 2'b10);
    cycle();
    r_v_i = 1'b1;
    r_idx_i = 3'd7;
    for (int i = 0; i < 6; i++) begin
      exp_pred.push_back(32'd0);
      chk("stall_r_ready", {31'b0, r_ready_o}, 1);
      cycle();
    end
    chk("upd_stalled", exp_wr.size(), 1);
    r_v_i = 1'b0;
    cycle();
    cycle();
    chk("upd_done_2cyc", exp_wr.size(), 0);
    repeat (3) cycle();
    do_lookup(3'd3, 1'b1);

    // Fill the queue under continuous lookups; fifth enters only with a pop
    cycle();
    r_v_i = 1'b1;
    r_idx_i = 3'd7;
    for (int i = 0; i < 4; i++) begin
      w_v_i = 1'b1;
      w_idx_i = 3'd1;
      w_taken_i = 1'b1;
      exp_wr.push_back({27'b0, 3'd1, g_vals[i]});
      exp_pred.push_back(32'd0);
      chk("fill_w_ready", {31'b0, w_ready_o}, 1);
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      exp_pred.push_back(32'd0);
      chk("full_w_ready", {31'b0, w_ready_o}, 0);
      cycle();
    end
    r_v_i = 1'b0;
    n = 0;
    while (!w_ready_o && n < 10) begin
      cycle();
      n++;
    end
    chk("fifth_wait", n, 2);
    exp_wr.push_back({27'b0, 3'd1, 2'b11});
    cycle();
    w_v_i = 1'b0;
    repeat (16) cycle();
    chk("drain_writes", exp_wr.size(), 0);
    do_lookup(3'd1, 1'b1);

    // clear_i during UPD_WR: no write, INIT restarts at address 0
    chk("pre_clr_w_ready", {31'b0, w_ready_o}, 1);
    w_v_i = 1'b1;
    w_idx_i = 3'd4;
    w_taken_i = 1'b1;
    cycle();
    w_v_i = 1'b0;
    cycle();
    cycle();
    chk("updwr_r_ready", {31'b0, r_ready_o}, 0);
    for (int a = 0; a < 8; a++) exp_wr.push_back({27'b0, 3'(a), 2'b01});
    clear_i = 1'b1;
    cycle();
    clear_i = 1'b0;
    chk("clr_init_done", {31'b0, init_done_o}, 0);
    chk("clr_r_ready",   {31'b0, r_ready_o}, 0);
    chk("clr_w_ready",   {31'b0, w_ready_o}, 0);
    n = 0;
    while (!init_done_o && n < 20) begin
      cycle();
      n++;
    end
    chk("reinit_cycles", n, 8);
    chk("reinit_writes", exp_wr.size(), 0);
    repeat (6) cycle();
    do_lookup(3'd4, 1'b0);
    do_lookup(3'd1, 1'b0);
    do_lookup(3'd5, 1'b0);

    repeat (4) cycle();
    chk("wr_queue_empty",   exp_wr.size(), 0);
    chk("pred_queue_empty", exp_pred.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bp_fe_bht_ctrl.md
BP_FE_BHT_CTRL -- requirements
Module: bp_fe_bht_ctrl

Interface
REQ-001 Parameter bht_idx_width_p, "inv", index width; entries = 2**bht_idx_width_p.
REQ-002 Parameter upd_els_p, 4, update-queue depth (power of two, >=2).
REQ-003 clk_i  in  1  sole clock; all state on posedge.
REQ-004 reset_n_i  in  1  asynchronous, active-low reset.
REQ-005 clear_i  in  1  restart table initialization.
REQ-006 init_done_o  out  1  table initialized.
REQ-007 r_v_i / r_idx_i  in  1 / bht_idx_width_p  fetch lookup request / index.
REQ-008 r_ready_o  out  1  lookup accepted when r_v_i & r_ready_o.
REQ-009 predict_v_o / predict_o  out  1 / 1  prediction valid / taken.
REQ-010 w_v_i / w_idx_i / w_taken_i  in  1 / bht_idx_width_p / 1  resolved-branch update / index / direction.
REQ-011 w_ready_o  out  1  update accepted when w_v_i & w_ready_o.
REQ-012 mem_v_o / mem_w_o / mem_addr_o / mem_data_o  out  1 / 1 / bht_idx_width_p / 2  single-port counter array command.
REQ-013 mem_data_i  in  2  array read data, valid one cycle after a read command.

Function
REQ-014 Counter encoding SHALL be 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; init value 01.
REQ-015 FSM states SHALL be INIT, IDLE, UPD_RD, UPD_WR.
REQ-016 INIT SHALL write 01 to addresses 0..entries-1, one per cycle, ascending, then go IDLE and assert init_done_o.
REQ-017 During INIT r_ready_o SHALL be 0; w_ready_o SHALL be 0.
REQ-018 clear_i SHALL, in any state, flush the update queue, abort any in-flight update, reset the init counter to 0 and enter INIT next cycle; init_done_o drops next cycle.
REQ-019 Outside INIT, r_ready_o SHALL be 1 except in UPD_WR.
REQ-020 An accepted lookup SHALL issue a read (mem_v_o=1, mem_w_o=0, mem_addr_o=r_idx_i) the same cycle.
REQ-021 predict_v_o SHALL be 1 exactly one cycle after an accepted lookup, with predict_o = mem_data_i[1]; otherwise predict_v_o=0 and predict_o=0.
REQ-022 Accepted updates SHALL enter a FIFO of upd_els_p entries; w_ready_o = ~full & init_done_o.
REQ-023 IDLE->UPD_RD when queue non-empty and no accepted lookup this cycle; UPD_RD issues read of head index.
REQ-024 UPD_RD SHALL not issue a read in a cycle with an accepted lookup (lookup wins); it waits in UPD_RD.
REQ-025 UPD_RD->UPD_WR after its read; UPD_WR writes saturated counter (taken: +1 capped at 11; not-taken: -1 floored at 00), pops the queue, then returns to IDLE.
REQ-026 UPD_WR SHALL take priority over lookups (r_ready_o=0 that cycle).
REQ-027 Lookup to an index with a queued/in-flight update SHALL return the array's current value (no bypass).
REQ-028 Enqueue and dequeue in the same cycle SHALL be legal when full; occupancy unchanged.
REQ-029 At most one array command per cycle.

Reset
REQ-030 reset_n_i low SHALL asynchronously set state INIT, init counter 0, queue empty, init_done_o=0, predict_v_o=0, predict_o=0, mem_v_o=0.
REQ-031 After reset release, INIT SHALL begin on the first clock edge.

Structure
REQ-032 State enum and the 2-bit counter init constant SHALL live in bp_fe_pkg.
REQ-033 The update queue SHALL be an instance of bsg_fifo_1r1w_small; the saturating arithmetic is inline.

Verification
REQ-034 bht_idx_width_p=3: release reset -> 8 writes of 01 to addr 0..7, init_done_o=1 in cycle 9.
REQ-035 After init, lookup idx 5 -> predict_v_o=1, predict_o=0 next cycle.
REQ-036 Two updates idx 5 taken, then lookup idx 5 -> counter 11, predict_o=1; third taken keeps 11.
REQ-037 Continuous lookups every cycle with one queued update -> update stalls in UPD_RD, completes within 2 cycles of first idle lookup cycle.
REQ-038 Enqueue 4 updates with lookups held -> w_ready_o=0; fifth update accepted only when a pop coincides.
REQ-039 clear_i asserted during UPD_WR -> no write issued, queue empty, INIT restarts at addr 0.
